sprite_mover: RTL and testbench

Hardware initiator for the sprite register bank: once per video frame it walks the actor slots (PacMan, Blinky, Pinky, Inky, Clyde) over the bank's register port. For each actor it decrements the move timer. On expiry it reloads the timer from the wait register and steps the actor one pixel along its rotation. It shares the register port with the CPU through a request/grant pair, taking over the per-frame bookkeeping the CPU currently does in software.

---
 rtl/sprite_pkg.sv | 52 +++++
 rtl/sprite_step.sv | 23 ++
 rtl/sprite_mover.sv | 188 ++++++++++++++++++
 tb/tb_sprite_mover.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the sprite register bank.
// Slot bases, register offsets, rot encoding and the mover FSM states.
package sprite_pkg;

  localparam logic [5:0] BASE_PACMAN = 6'd0;
  localparam logic [5:0] BASE_BLINKY = 6'd8;
  localparam logic [5:0] BASE_PINKY  = 6'd13;
  localparam logic [5:0] BASE_INKY   = 6'd18;
  localparam logic [5:0] BASE_CLYDE  = 6'd23;

  localparam logic [5:0] OFS_POS_X = 6'd0;
  localparam logic [5:0] OFS_POS_Y = 6'd1;
  localparam logic [5:0] OFS_ROT   = 6'd2;
  localparam logic [5:0] OFS_TIMER = 6'd3;
  localparam logic [5:0] OFS_WAIT  = 6'd4;

  typedef enum logic [1:0] {
    ROT_XP = 2'd0,
    ROT_YP = 2'd1,
    ROT_XM = 2'd2,
    ROT_YM = 2'd3
  } rot_e;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    RD_TIMER,
    WR_TIMER,
    RD_WAIT,
    WR_RELOAD,
    RD_ROT,
    RD_POS,
    WR_POS,
    FIN
  } state_e;

  // Slot 0 is PacMan, slots 1.. are the ghosts.
  function automatic logic [5:0] slot_base(
    input logic [2:0] slot
  );
    logic [5:0] b;
    unique case (slot)
      3'd0:    b = BASE_PACMAN;
      3'd1:    b = BASE_BLINKY;
      3'd2:    b = BASE_PINKY;
      3'd3:    b = BASE_INKY;
      default: b = BASE_CLYDE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sprite_step.sv
// sprite_step: steps a position byte one pixel along a rotation.
// Ports: rot[1:0], pos[7:0] in; pos_nxt[7:0], sel_y (1 = y axis) out.
module sprite_step
  import sprite_pkg::*;
(
  input  logic [1:0] rot,
  input  logic [7:0] pos,
  output logic [7:0] pos_nxt,
  output logic       sel_y
);

  // rot[0] picks the axis, rot[1] the direction; wrap is 8-bit.
  always_comb begin
    pos_nxt = pos;
    sel_y   = rot[0];
    unique case (rot_e'(rot))
      ROT_XP, ROT_YP: pos_nxt = pos + 8'd1;
      ROT_XM, ROT_YM: pos_nxt = pos - 8'd1;
      default:        pos_nxt = pos;
    endcase
  end

endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: per-frame timer/position update of the actor slots.
// Ports: clk, reset (async low), start, bus_req/bus_gnt, reg_addr,
//   reg_wdata, reg_we, reg_rdata, busy, done.
// Build macro SPRITE_MOVER_PACMAN_EN: also process the PacMan slot.
module sprite_mover
  import sprite_pkg::*;
#(
  // Address map caps this at 4 ghost slots.
  parameter int NUM_GHOSTS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [5:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  input  logic [15:0] reg_rdata,
  output logic        busy,
  output logic        done
);

`ifdef SPRITE_MOVER_PACMAN_EN
  localparam logic [2:0] FIRST = 3'd0;
`else
  localparam logic [2:0] FIRST = 3'd1;
`endif
  localparam logic [2:0] LAST = 3'(NUM_GHOSTS);

  state_e     st_q, st_d;
  logic [2:0] slot_q, slot_d;
  logic [1:0] rot_q, rot_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       stall;
  logic       last;
  logic [5:0] base_d;
  logic [7:0] rd8;
  logic [1:0] step_rot;
  logic [7:0] step_pos;
  logic       step_sel_y;
  logic       unused_rdata_hi;

  assign rd8 = reg_rdata[7:0];
  assign unused_rdata_hi = ^reg_rdata[15:8];
  assign last = (slot_q == LAST);
  assign base_d = slot_base(slot_d);

  // FIN does not touch the port, so it never waits on grant.
  assign stall = !bus_gnt
              && (st_q != IDLE)
              && (st_q != REQ)
              && (st_q != FIN);

  // In RD_ROT the rot is still on the bus; later it comes from rot_q.
  assign step_rot = (st_q == RD_ROT) ? rd8[1:0] : rot_q;

  sprite_step u_step (
    .rot     (step_rot),
    .pos     (rd8),
    .pos_nxt (step_pos),
    .sel_y   (step_sel_y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= IDLE;
      slot_q  <= '0;
      rot_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      slot_q  <= slot_d;
      rot_q   <= rot_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    slot_d = slot_q;
    rot_d  = rot_q;
    if (!stall) begin
      unique case (st_q)
        IDLE: begin
          if (start) begin
            st_d   = REQ;
            slot_d = FIRST;
          end
        end
        REQ: begin
          if (bus_gnt) st_d = RD_TIMER;
        end
        RD_TIMER: begin
          st_d = (rd8 != 8'd0) ? WR_TIMER : RD_WAIT;
        end
        RD_WAIT:   st_d = WR_RELOAD;
        WR_RELOAD: st_d = RD_ROT;
        RD_ROT: begin
          st_d  = RD_POS;
          rot_d = rd8[1:0];
        end
        RD_POS: st_d = WR_POS;
        WR_TIMER, WR_POS: begin
          if (last) begin
            st_d = FIN;
          end else begin
            st_d   = RD_TIMER;
            slot_d = slot_q + 3'd1;
          end
        end
        FIN:     st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  // Outputs are registered: compute what the next state presents.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (!stall) begin
      addr_d  = base_d + OFS_TIMER;
      wdata_d = 8'd0;
      we_d    = 1'b0;
      busy_d  = 1'b1;
      unique case (st_d)
        IDLE: begin
          addr_d = '0;
          busy_d = 1'b0;
        end
        REQ, RD_TIMER: begin
        end
        WR_TIMER: begin
          wdata_d = rd8 - 8'd1;
          we_d    = 1'b1;
        end
        RD_WAIT: addr_d = base_d + OFS_WAIT;
        WR_RELOAD: begin
          wdata_d = rd8;
          we_d    = 1'b1;
        end
        RD_ROT: addr_d = base_d + OFS_ROT;
        RD_POS: begin
          addr_d = base_d
                 + (step_sel_y ? OFS_POS_Y : OFS_POS_X);
        end
        WR_POS: begin
          addr_d  = addr_q;
          wdata_d = step_pos;
          we_d    = 1'b1;
        end
        FIN: begin
          addr_d = addr_q;
          done_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // A pending write is held while grant is away and strobes on return,
  // so it commits exactly once and never on the CPU's cycles.
  assign reg_we    = we_q & bus_gnt;
  assign reg_addr  = addr_q;
  assign reg_wdata = {8'h00, wdata_q};
  assign bus_req   = busy_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: register bank model plus per-pass behavioural model.
// Directed passes: decrement, reload/step, wrap, stall, reset abort.
module tb_sprite_mover;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        bus_req;
  logic        bus_gnt;
  logic [5:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic [15:0] reg_rdata;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  sprite_mover #(.NUM_GHOSTS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .done      (done)
  );

`ifdef SPRITE_MOVER_PACMAN_EN
  localparam int FIRST = 0;
`else
  localparam int FIRST = 1;
`endif

  logic [15:0] bank     [64];
  logic [15:0] init_mem [64];
  logic [15:0] exp_mem  [64];
  logic        load_bank;

  always @(posedge clk) begin
    if (load_bank) begin
      for (int i = 0; i < 64; i++) bank[i] <= init_mem[i];
    end else if (reg_we) begin
      bank[reg_addr] <= reg_wdata;
    end
  end
  assign reg_rdata = bank[reg_addr];

  typedef struct {
    logic [5:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  exp_cycles;
  int  checks = 0;
  int  failures = 0;
  int  bases[5] = '{0, 8, 13, 18, 23};

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_eq(input string nm,
                        input longint act, input longint req);
    chk(act == req, nm, act, req);
  endtask

  task automatic push(input int a, input logic [7:0] d);
    wr_t w;
    exp_mem[a] = {8'h00, d};
    w.a = 6'(a);
    w.d = {8'h00, d};
    exp_q.push_back(w);
  endtask

  // What one pass must do to the bank, from the actor rules alone.
  task automatic build_model();
    logic [7:0] t, w, p, np;
    logic [1:0] r;
    int b, pa;
    exp_q.delete();
    exp_cycles = 2;
    for (int i = 0; i < 64; i++) exp_mem[i] = bank[i];
    for (int s = FIRST; s < 5; s++) begin
      b = bases[s];
      t = exp_mem[b+3][7:0];
      if (t != 8'd0) begin
        push(b + 3, t - 8'd1);
        exp_cycles += 2;
      end else begin
        w = exp_mem[b+4][7:0];
        push(b + 3, w);
        r = exp_mem[b+2][1:0];
        pa = b + (r[0] ? 1 : 0);
        p = exp_mem[pa][7:0];
        np = (r < 2'd2) ? p + 8'd1 : p - 8'd1;
        push(pa, np);
        exp_cycles += 6;
      end
    end
  endtask

  // Every cycle: sample at negedge and check the port behaviour.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    if (reset) begin
      chk_eq("req_vs_busy", bus_req, busy);
      if (!bus_gnt) chk_eq("we_ungranted", reg_we, 0);
`ifndef SPRITE_MOVER_PACMAN_EN
      if (busy) chk(reg_addr >= 6'd5, "pacman_addr", reg_addr, 5);
`endif
      if (reg_we) begin
        chk(exp_q.size() > 0, "write_expected", reg_addr, -1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk_eq("wr_addr", reg_addr, w.a);
          chk_eq("wr_data", reg_wdata, w.d);
        end
      end
    end
  endtask

  task automatic run_pass(input int mid_at, input bit sod,
                          input int stall_addr, input int stall_len,
                          output int n);
    int dn, da, sc, mism;
    bit stalled;
    build_model();
    start = 1'b1;
    tick();
    chk_eq("busy_after_start", busy, 1);
    n = 0; dn = 0; da = 0; sc = 0; stalled = 0;
    for (int c = 0; c < 200 && busy; c++) begin
      n++;
      if (done) begin
        dn++;
        da = n;
      end
      start = (n == mid_at) || (done && sod);
      if (!bus_gnt) begin
        sc++;
        if (sc == stall_len) bus_gnt = 1'b1;
      end else if (!stalled && int'(reg_addr) == stall_addr) begin
        bus_gnt = 1'b0;
        stalled = 1;
      end
      tick();
    end
    bus_gnt = 1'b1;
    chk_eq("pass_cycles", n,
           exp_cycles + (stall_addr >= 0 ? stall_len : 0));
    chk_eq("done_count", dn, 1);
    chk_eq("done_last_cycle", da, n);
    chk_eq("writes_left", exp_q.size(), 0);
    mism = 0;
    for (int i = 0; i < 64; i++) if (bank[i] !== exp_mem[i]) mism++;
    chk_eq("bank_mismatches", mism, 0);
  endtask

  int n1, n2, n3, n5;
  bit hit;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    bus_gnt = 1'b1;
    load_bank = 1'b1;
    for (int i = 0; i < 64; i++) init_mem[i] = 16'h0000;
    init_mem[0]  = 16'd50;  init_mem[1]  = 16'd60;
    init_mem[2]  = 16'd0;   init_mem[3]  = 16'd0;
    init_mem[4]  = 16'd7;
    init_mem[8]  = 16'd100; init_mem[9]  = 16'd100;
    init_mem[10] = 16'h0005; init_mem[11] = 16'hAB03;
    init_mem[12] = 16'd9;
    init_mem[13] = 16'd0;   init_mem[14] = 16'd40;
    init_mem[15] = 16'h0002; init_mem[16] = 16'd0;
    init_mem[17] = 16'd5;
    init_mem[18] = 16'd255; init_mem[19] = 16'd7;
    init_mem[20] = 16'h00FC; init_mem[21] = 16'd2;
    init_mem[22] = 16'd4;
    init_mem[23] = 16'd30;  init_mem[24] = 16'd10;
    init_mem[25] = 16'h0003; init_mem[26] = 16'd0;
    init_mem[27] = 16'd1;

    tick();
    chk_eq("rst_bus_req", bus_req, 0);
    chk_eq("rst_reg_addr", reg_addr, 0);
    chk_eq("rst_reg_wdata", reg_wdata, 0);
    chk_eq("rst_reg_we", reg_we, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    tick();
    load_bank = 1'b0;
    reset = 1'b1;
    tick();
    chk_eq("idle_busy", busy, 0);

    build_model();
    chk(exp_q.size() > 0, "model_nonempty", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      chk_eq("model_first_addr", exp_q[0].a, 11);
      chk_eq("model_first_data", exp_q[0].d, 2);
    end
`ifndef SPRITE_MOVER_PACMAN_EN
    chk_eq("model_cycles", exp_cycles, 18);
`endif

    // Pass 1: Blinky decrement, Pinky x wrap, Clyde y step.
    run_pass(0, 1'b1, -1, 0, n1);
    chk_eq("p1_blinky_timer", bank[11], 2);
    chk_eq("p1_blinky_x", bank[8], 100);
    chk_eq("p1_blinky_y", bank[9], 100);
    chk_eq("p1_pinky_timer", bank[16], 5);
    chk_eq("p1_pinky_x", bank[13], 255);
    chk_eq("p1_pinky_y", bank[14], 40);
    chk_eq("p1_clyde_timer", bank[26], 1);
    chk_eq("p1_clyde_y", bank[24], 9);
`ifndef SPRITE_MOVER_PACMAN_EN
    chk_eq("p1_cycles", n1, 18);
    chk_eq("p1_pac_timer", bank[3], 0);
    chk_eq("p1_pac_x", bank[0], 50);
`endif
    chk_eq("start_on_done_ignored", busy, 0);

    // Pass 2 starts one cycle after done; stray start mid-pass.
    run_pass(4, 1'b0, -1, 0, n2);
    chk_eq("p2_clyde_timer", bank[26], 0);
    chk_eq("p2_clyde_y", bank[24], 9);
`ifndef SPRITE_MOVER_PACMAN_EN
    chk_eq("p2_cycles", n2, 10);
`endif
    start = 1'b0;
    tick();
    chk_eq("mid_start_ignored", busy, 0);

    // Pass 3: grant drops for 4 cycles while Inky's rot is read.
    run_pass(0, 1'b0, 20, 4, n3);
    chk_eq("p3_inky_x", bank[18], 0);
    chk_eq("p3_inky_timer", bank[21], 4);
    chk_eq("p3_clyde_y", bank[24], 8);
`ifndef SPRITE_MOVER_PACMAN_EN
    chk_eq("p3_cycles", n3, 22);
`endif
    start = 1'b0;
    tick();

    // Pass 4: reset while Blinky's y write is on the port.
    build_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (reg_we && reg_addr == 6'd9) hit = 1;
      else tick();
    end
    chk_eq("wr_pos_reached", hit, 1);
    reset = 1'b0;
    #1;
    chk_eq("abort_bus_req", bus_req, 0);
    chk_eq("abort_reg_addr", reg_addr, 0);
    chk_eq("abort_reg_wdata", reg_wdata, 0);
    chk_eq("abort_reg_we", reg_we, 0);
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_done", done, 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_eq("abort_idle", busy, 0);
    chk_eq("abort_blinky_timer", bank[11], 9);
    chk_eq("abort_blinky_y", bank[9], 100);
    chk_eq("abort_pinky_timer", bank[16], 3);

    // Pass 5: normal pass after the abort.
    run_pass(0, 1'b0, -1, 0, n5);
    chk_eq("p5_blinky_timer", bank[11], 8);
    chk_eq("p5_blinky_y", bank[9], 100);
`ifndef SPRITE_MOVER_PACMAN_EN
    chk_eq("p5_cycles", n5, 10);
`endif
    start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
